// File: rtl/pe_sched_pkg.sv
// Shared types and constants for the pe_sched round-robin pe scheduler.
package pe_sched_pkg;

  localparam int ELEM_W = 4;
  localparam int RES_W  = 9;
  localparam int NELEM  = 4;

  // Element order within a matrix word: {x22, x21, x12, x11}
  typedef logic [NELEM-1:0][ELEM_W-1:0] mat_in_t;
  typedef logic [NELEM-1:0][RES_W-1:0]  mat_out_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pe_sched_tagq.sv
// In-order requester-ID FIFO; same-cycle push/pop reads the head before the push lands.
module pe_sched_tagq #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_dout  = r_mem[r_rp];

  // A pop on an empty queue is ignored; a push while full is legal only alongside a pop
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

endmodule

// File: rtl/pe_sched.sv
// Round-robin scheduler sharing one 2x2 multiply pe between NREQ requesters.
// Optional PE_SCHED_STATS_EN adds saturating accept/stall counters.
module pe_sched
  import pe_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 4,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_val,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic                 pe_in_val,
  output mat_in_t              pe_a,
  output mat_in_t              pe_b,
  input  logic                 pe_out_val,
  input  mat_out_t             pe_c,
  output logic                 rsp_val,
  output logic [IDW-1:0]       rsp_id,
  output mat_out_t             rsp_c,
  input  logic                 drain_req,
  output logic                 drain_done,
  output logic                 err_unexp
`ifdef PE_SCHED_STATS_EN
  ,output logic [15:0]         stat_jobs
  ,output logic [15:0]         stat_stall
`endif
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = IDW + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(MAX_OUT);

  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_IDLE  = IDLE;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [IDW-1:0]        r_rr;
  logic [CW-1:0]         r_cred;
  logic [CW-1:0]         w_cred_nxt;
  logic [NREQ-1:0][15:0] w_a_arr;
  logic [NREQ-1:0][15:0] w_b_arr;
  logic [IDW-1:0]        w_gnt_idx;
  logic                  w_found;
  logic                  w_ret;
  logic                  w_gnt_ok;
  logic                  w_acc;
  logic [IDW-1:0]        w_head;
  logic                  w_full;
  logic                  w_empty;

  assign w_a_arr = req_a;
  assign w_b_arr = req_b;

  // First requesting index at or after r_rr, with wrap
  always_comb begin
    logic [PW-1:0]  t;
    logic [IDW-1:0] idx;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    t         = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      t = {1'b0, r_rr} + PW'(k);
      if (t >= PW'(NREQ)) t = t - PW'(NREQ);
      idx = t[IDW-1:0];
      if (!w_found && req_val[idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  // Only results with a matching tag return a credit; strays do not
  assign w_ret    = pe_out_val & ~w_empty;
  assign w_gnt_ok = (r_state == S_RUN) && (r_cred != '0 || w_ret) && (!w_full || w_ret);
  assign w_acc    = w_gnt_ok & w_found;

  always_comb begin
    req_rdy = '0;
    if (w_acc) req_rdy[w_gnt_idx] = 1'b1;
  end

  assign w_cred_nxt = r_cred - CW'(w_acc) + CW'(w_ret);

  pe_sched_tagq #(
    .W     (IDW),
    .DEPTH (MAX_OUT)
  ) u_tagq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_acc),
    .i_din   (w_gnt_idx),
    .i_pop   (pe_out_val),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Drain completes once every credit is home and nothing is waiting to issue
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (drain_req) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!drain_req)                                    w_state_nxt = S_RUN;
        else if (w_cred_nxt == CRED_MAX && !pe_in_val && !w_acc) w_state_nxt = S_IDLE;
      end
      S_IDLE:  if (!drain_req) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign drain_done = (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_rr    <= '0;
      r_cred  <= CRED_MAX;
    end else begin
      r_state <= w_state_nxt;
      r_cred  <= w_cred_nxt;
      if (w_acc) r_rr <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_in_val <= 1'b0;
      pe_a      <= '0;
      pe_b      <= '0;
    end else begin
      pe_in_val <= w_acc;
      if (w_acc) begin
        pe_a <= w_a_arr[w_gnt_idx];
        pe_b <= w_b_arr[w_gnt_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_val   <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
      err_unexp <= 1'b0;
    end else begin
      rsp_val <= pe_out_val;
      if (pe_out_val) begin
        rsp_c  <= pe_c;
        rsp_id <= w_empty ? '0 : w_head;
      end
      if (pe_out_val && w_empty) err_unexp <= 1'b1;
    end
  end

`ifdef PE_SCHED_STATS_EN
  logic r_unused_stat;
  logic w_stall;

  assign w_stall = (|req_val) && !w_acc &&
                   ((r_state != S_RUN) || (r_cred == '0 && !w_ret));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_jobs     <= '0;
      stat_stall    <= '0;
      r_unused_stat <= 1'b0;
    end else begin
      if (w_acc && stat_jobs != 16'hFFFF)    stat_jobs  <= stat_jobs + 16'd1;
      if (w_stall && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_sched.sv
// Scoreboard bench for pe_sched: bench models the pe and a queue-level reference scheduler.
module tb_pe_sched;

  localparam int NREQ    = 4;
  localparam int MAX_OUT = 4;
  localparam int IDW     = 2;
  localparam int L       = 2;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_IDLE  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_val = '0;
  logic [NREQ-1:0]     req_rdy;
  logic [NREQ*16-1:0]  req_a = '0;
  logic [NREQ*16-1:0]  req_b = '0;
  logic                pe_in_val;
  logic [15:0]         pe_a;
  logic [15:0]         pe_b;
  logic                pe_out_val = 1'b0;
  logic [35:0]         pe_c = '0;
  logic                rsp_val;
  logic [IDW-1:0]      rsp_id;
  logic [35:0]         rsp_c;
  logic                drain_req = 1'b0;
  logic                drain_done;
  logic                err_unexp;
`ifdef PE_SCHED_STATS_EN
  logic [15:0]         stat_jobs;
  logic [15:0]         stat_stall;
`endif

  pe_sched #(.NREQ(NREQ), .MAX_OUT(MAX_OUT), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_a      (req_a),
    .req_b      (req_b),
    .pe_in_val  (pe_in_val),
    .pe_a       (pe_a),
    .pe_b       (pe_b),
    .pe_out_val (pe_out_val),
    .pe_c       (pe_c),
    .rsp_val    (rsp_val),
    .rsp_id     (rsp_id),
    .rsp_c      (rsp_c),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .err_unexp  (err_unexp)
`ifdef PE_SCHED_STATS_EN
    ,.stat_jobs  (stat_jobs)
    ,.stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] a; logic [15:0] b; } job_t;
  typedef struct { int id; logic [35:0] c; } rsp_t;
  typedef struct { int due; logic [35:0] c; } pe_t;

  job_t jq [NREQ][$];
  rsp_t mq[$];
  rsp_t sb[$];
  pe_t  pipe[$];
  int   rsp_log[$];
  logic [NREQ-1:0] gnt_log[$];

  int total = 0;
  int bad   = 0;
  int rr = 0, mode = M_RUN;
  bit m_err = 0, hold = 0, inj = 0, exp_piv = 0, exp_rv = 0;
  logic [15:0] exp_pa = '0, exp_pb = '0;
  int acc_cyc = 0, rsp_cyc = 0, last_id = 0;
  logic [35:0] last_c = '0;

  function automatic logic [35:0] mm(input logic [15:0] a, input logic [15:0] b);
    int a11, a12, a21, a22, b11, b12, b21, b22;
    a11 = int'(a[3:0]);   a12 = int'(a[7:4]);   a21 = int'(a[11:8]); a22 = int'(a[15:12]);
    b11 = int'(b[3:0]);   b12 = int'(b[7:4]);   b21 = int'(b[11:8]); b22 = int'(b[15:12]);
    return {9'(a21*b12 + a22*b22), 9'(a21*b11 + a22*b21),
            9'(a11*b12 + a12*b22), 9'(a11*b11 + a12*b21)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      req_val[i] = (jq[i].size() > 0);
      if (jq[i].size() > 0) begin
        req_a[i*16 +: 16] = jq[i][0].a;
        req_b[i*16 +: 16] = jq[i][0].b;
      end
    end
  endtask

  // The pe: fixed latency L from pe_in_val, optionally held back by the bench
  task automatic drive_pe();
    pe_out_val = 1'b0;
    if (inj) begin
      pe_out_val = 1'b1;
      pe_c = 36'({$urandom(), $urandom()});
      inj = 0;
    end else if (!hold && pipe.size() > 0 && pipe[0].due <= cyc) begin
      pe_out_val = 1'b1;
      pe_c = pipe[0].c;
      void'(pipe.pop_front());
    end
  endtask

  task automatic push_job(input int i, input logic [15:0] a, input logic [15:0] b);
    jq[i].push_back('{a, b});
    drive_req();
  endtask

  task automatic push_rand(input int i);
    push_job(i, 16'($urandom()), 16'($urandom()));
  endtask

  // Reference: credits = MAX_OUT - jobs in flight; grant first valid from rr with wrap
  task automatic model_eval();
    int g;
    bit ret;
    logic [NREQ-1:0] exp_rdy;
    chk("pe_in_val", pe_in_val, exp_piv);
    if (exp_piv) begin
      chk("pe_a", pe_a, exp_pa);
      chk("pe_b", pe_b, exp_pb);
    end
    chk("rsp_val", rsp_val, exp_rv);
    chk("drain_done", drain_done, mode == M_IDLE);
    chk("err_unexp", err_unexp, m_err);
    if (pe_in_val) pipe.push_back('{cyc + L, mm(pe_a, pe_b)});
    ret = pe_out_val && mq.size() > 0;
    g = -1;
    if (mode == M_RUN && (mq.size() < MAX_OUT || ret)) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx = (rr + k) % NREQ;
        if (g < 0 && req_val[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_rdy", req_rdy, exp_rdy);
    if (req_rdy != '0) gnt_log.push_back(req_rdy);
    exp_rv = pe_out_val;
    if (pe_out_val) begin
      if (ret) sb.push_back(mq.pop_front());
      else begin
        sb.push_back('{0, pe_c});
        m_err = 1;
      end
    end
    exp_piv = (g >= 0);
    if (g >= 0) begin
      mq.push_back('{g, mm(jq[g][0].a, jq[g][0].b)});
      exp_pa = jq[g][0].a;
      exp_pb = jq[g][0].b;
      void'(jq[g].pop_front());
      rr = (g + 1) % NREQ;
      acc_cyc = cyc;
    end
    case (mode)
      M_RUN:   if (drain_req) mode = M_DRAIN;
      M_DRAIN: if (!drain_req) mode = M_RUN; else if (mq.size() == 0) mode = M_IDLE;
      default: if (!drain_req) mode = M_RUN;
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      model_eval();
      @(posedge clk);
      #1;
      drive_req();
      drive_pe();
    end
  endtask

  task automatic check_reset_outs();
    chk("rst_pe", {pe_in_val, pe_a, pe_b}, '0);
    chk("rst_rsp", {rsp_val, rsp_id, rsp_c}, '0);
    chk("rst_misc", {req_rdy, drain_done, err_unexp}, '0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) jq[i].delete();
    req_val = '0;
    pe_out_val = 1'b0;
    drain_req = 1'b0;
    #1;
    check_reset_outs();
    mq.delete();
    pipe.delete();
    rr = 0; mode = M_RUN; m_err = 0; exp_piv = 0; exp_rv = 0; hold = 0; inj = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_req();
    drive_pe();
  endtask

  task automatic settle(input int budget);
    int n = 0;
    while ((mq.size() > 0 || pipe.size() > 0 || sb.size() > 0) && n < budget) begin
      step(1);
      n++;
    end
    chk("settle_empty", mq.size() + pipe.size() + sb.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge clk) begin : mon
    rsp_t e;
    if (rst) sb.delete();
    else if (rsp_val) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_extra: got id %0d c %0h, expected no response", rsp_id, rsp_c);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_c", rsp_c, e.c);
        last_id = int'(rsp_id);
        last_c  = rsp_c;
        rsp_cyc = cyc;
        rsp_log.push_back(int'(rsp_id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #1 rst = 1'b1;
    #1 check_reset_outs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive_req();
    drive_pe();

    // Fairness from rr=0: expect 0,1,2,3,0,1
    gnt_log.delete();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NREQ; i++) push_rand(i);
    step(6);
    for (int k = 0; k < 6; k++) begin
      if (k < gnt_log.size()) chk("fair_order", gnt_log[k], 4'b0001 << (k % 4));
      else chk("fair_count", gnt_log.size(), 6);
    end
    settle(40);

    // Single job with known product and end-to-end latency
    push_job(2, 16'h4321, 16'h8765);
    step(L + 5);
    chk("single_id", last_id, 2);
    chk("single_c", last_c, {9'd50, 9'd43, 9'd22, 9'd19});
    chk("single_lat", rsp_cyc - acc_cyc, L + 2);
    settle(20);

    // Credit cap with pe held off, then grant on the first return cycle
    hold = 1;
    gnt_log.delete();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NREQ; i++) push_rand(i);
    step(8);
    chk("credit_cap", gnt_log.size(), MAX_OUT);
    hold = 0;
    step(20);
    settle(40);

    // Tag order 3,1,0,3, then push+pop at full on release
    hold = 1;
    rsp_log.delete();
    push_rand(3); step(1);
    push_rand(1); step(1);
    push_rand(0); step(1);
    push_rand(3); step(1);
    push_rand(2); push_rand(1);
    step(3);
    hold = 0;
    step(15);
    settle(30);
    cnt = rsp_log.size();
    chk("order_count", cnt, 6);
    if (cnt >= 4) begin
      chk("order0", rsp_log[0], 3);
      chk("order1", rsp_log[1], 1);
      chk("order2", rsp_log[2], 0);
      chk("order3", rsp_log[3], 3);
    end

    // Drain with 3 in flight
    hold = 1;
    push_rand(0); push_rand(1); push_rand(2);
    step(4);
    drain_req = 1'b1;
    push_rand(3);
    step(4);
    hold = 0;
    step(10);
    chk("drain_done_hi", drain_done, 1);
    drain_req = 1'b0;
    step(5);
    settle(30);

    // Randomized traffic with holds and drain toggles
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(2) == 0 && jq[i].size() < 3) push_rand(i);
      hold = ($urandom_range(4) == 0);
      if ($urandom_range(39) == 0) drain_req = ~drain_req;
      step(1);
    end
    hold = 0;
    drain_req = 1'b0;
    step(NREQ * 4);
    settle(60);

    // Stray result into an empty FIFO, same cycle as an accept
    rsp_log.delete();
    jq[1].push_back('{16'h1234, 16'h5678});
    inj = 1;
    step(1);
    step(L + 6);
    chk("err_sticky", err_unexp, 1);
    chk("stray_count", rsp_log.size(), 2);
    if (rsp_log.size() >= 2) begin
      chk("stray_id", rsp_log[0], 0);
      chk("stray_job_id", rsp_log[1], 1);
    end
    settle(20);

    // Reset mid-stream, then a stray from the old pe, then credits reloaded
    for (int i = 0; i < NREQ; i++) push_rand(i);
    step(3);
    do_reset();
    inj = 1;
    step(4);
    chk("err_after_rst", err_unexp, 1);
    hold = 1;
    gnt_log.delete();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 3; i++) push_rand(i);
    step(8);
    chk("credit_reload", gnt_log.size(), MAX_OUT);
    hold = 0;
    step(20);
    settle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_sched.md
Name: pe_sched

Overview:
- Round-robin scheduler that shares one pe (dual-wrapper 2x2 multiply, 4-bit operands, 9-bit results) between NREQ requesters.
- Accepts 2x2 jobs and issues them to the pe, at most one per cycle.
- Limits in-flight jobs with a credit counter, because the pe has no output backpressure.
- Tracks requester IDs in an in-order tag FIFO and returns each result with its ID. A drain FSM supports a quiesce before reconfiguration or power-down.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_OUT, 4, max jobs in flight inside the pe; also the tag FIFO depth (power of 2, >=2).
- IDW, $clog2(NREQ), requester ID width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_val  in  NREQ  per-requester job valid
- req_rdy  out  NREQ  per-requester grant; one-hot or zero
- req_a  in  NREQ*16  A operands per requester, {a22,a21,a12,a11} per 16-bit slice
- req_b  in  NREQ*16  B operands per requester, {b22,b21,b12,b11} per 16-bit slice
- pe_in_val  out  1  job valid to pe
- pe_a  out  16  {a22,a21,a12,a11} to pe
- pe_b  out  16  {b22,b21,b12,b11} to pe
- pe_out_val  in  1  result valid from pe
- pe_c  in  36  {c22,c21,c12,c11} from pe
- rsp_val  out  1  result valid; single-cycle pulse, no ready
- rsp_id  out  IDW  requester ID of the result
- rsp_c  out  36  {c22,c21,c12,c11}
- drain_req  in  1  level; stop granting and drain the pe
- drain_done  out  1  high while drained
- err_unexp  out  1  sticky: result arrived with the tag FIFO empty

Behaviour:
- Reset (async assert, sync release): all outputs 0; rr pointer 0; credits = MAX_OUT; tag FIFO empty; state RUN.
- Grant (combinational):
  - req_rdy[i]=1 for the first i with req_val[i], searching from rr_ptr upward with wrap.
  - Only when state==RUN and credits>0 (or a credit returns in the same cycle, see below).
  - Accept is req_val[i]&req_rdy[i]; at most one accept per cycle.
  - On accept, rr_ptr <= (i+1) mod NREQ. With no accept, rr_ptr holds.
- Issue: registered. The cycle after an accept, pe_in_val=1 and pe_a/pe_b carry the accepted slice. Otherwise pe_in_val=0 and pe_a/pe_b hold their last value.
- Credits:
  - Accept decrements; pe_out_val increments; both in one cycle leave the count unchanged.
  - A same-cycle return may enable a grant at credits==0.
  - Credits never exceed MAX_OUT.
- Tag FIFO:
  - Push the accepted ID on accept; pop on pe_out_val. Results return in issue order.
  - Push and pop in one cycle, including when full or empty: pop reads the head before the push lands, so a push into an empty FIFO is not popped in the same cycle.
  - Pointers wrap at MAX_OUT.
- Response: registered. The cycle after pe_out_val, rsp_val=1, rsp_c=pe_c, rsp_id=popped tag. Total latency from accept = 1 + pe latency + 1.
- err_unexp: pe_out_val with the FIFO empty sets it sticky until rst. That response is still emitted with rsp_id=0; credits are not incremented.
- FSM:
  - RUN: grants allowed. drain_req=1 -> DRAIN.
  - DRAIN: no grants; wait for credits==MAX_OUT and no issue pending, then -> IDLE.
  - IDLE: drain_done=1, no grants. drain_req=0 -> RUN.
  - drain_req dropped while in DRAIN -> RUN directly.
- drain_req rising in the same cycle as an accept: that accept completes and counts as in flight.
- rst mid-operation discards in-flight tags. The pe must be reset alongside; later stray results set err_unexp.

Optional Feature:
- Macro PE_SCHED_STATS_EN.
- Defined: adds output stat_jobs[15:0] (saturating count of accepts) and stat_stall[15:0] (saturating count of cycles with any req_val but no grant due to zero credits or non-RUN state). Both reset to 0.
- Undefined: the ports and counters are absent; there is no other behavioural difference.

Decomposition:
- Package pe_sched_pkg:
  - ELEM_W=4, RES_W=9, NELEM=4.
  - typedef mat_in_t = logic [NELEM-1:0][ELEM_W-1:0].
  - typedef mat_out_t = logic [NELEM-1:0][RES_W-1:0].
  - enum sched_state_e {RUN, DRAIN, IDLE}.
- Sub-module pe_sched_tagq: parameterised FIFO, width IDW, depth MAX_OUT, with same-cycle push/pop and full/empty flags.

Test Plan:
- Single job: req_val[2]=1, a={4,3,2,1}, b={8,7,6,5}, pe latency L.
  - req_rdy[2] pulses once; pe_in_val one cycle later.
  - rsp_val at accept+L+2 with rsp_id=2 and rsp_c={50,43,22,19}.
- Fairness: all 4 requesters hold req_val=1 with credits unconstrained -> grants in order 0,1,2,3,0,1 on consecutive cycles.
- Credit limit: MAX_OUT=4, pe_out_val held off -> exactly 4 accepts, then req_rdy=0. The first pe_out_val allows a grant in that same cycle.
- Order/tags: issue IDs 3,1,0,3 -> four responses in that order with matching rsp_id. Also cover simultaneous push+pop at full and at empty.
- Drain: raise drain_req with 3 in flight -> no new grants; drain_done=1 the cycle after the last credit returns. Drop drain_req -> grants resume next cycle.
- Error/reset: pe_out_val with no jobs -> err_unexp=1 and rsp_id=0. Assert rst mid-stream -> all outputs 0 immediately and credits reloaded.
